// File: rtl/retire_ctrl.sv
// retire_ctrl -- retirement sequencer between the ROB head and arch_table.
//
// Each cycle it retires an in-order, prefix-contiguous group of up to
// RETIRE_WIDTH completed head entries. For that group it drives the
// arch_table write ports and returns the displaced physical tags to the
// freelist. When a mispredicted branch retires, a FLUSH pulse follows,
// then RECOVER_CYCLES busy cycles, during which nothing retires.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   rob_head_*_i             per-slot ROB head info (slot 0 = oldest)
//   at_tag_i                 arch_table combinational read at retire_arch_reg_o
//   retire_en_o              arch_table write enables (youngest same-reg write only)
//   retire_arch_reg_o        arch_table write index
//   new_tag_o                arch_table write data
//   rob_retire_cnt_o         number of entries popped from the ROB this cycle
//   free_en_o / free_tag_o   freelist returns (forwarded within the group)
//   flush_o                  one-cycle flush / map-table restore pulse
//   recover_busy_o           high while in FLUSH or RECOVER
//   retired_total_o          running count of retired instructions (wraps)
module retire_ctrl #(
  parameter int RETIRE_WIDTH   = 2,
  parameter int ARCH_REGS      = 32,
  parameter int PREG_NUM       = 64,
  parameter int RECOVER_CYCLES = 2,
  localparam int AW   = $clog2(ARCH_REGS),
  localparam int PW   = $clog2(PREG_NUM),
  localparam int CNTW = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [RETIRE_WIDTH-1:0]          rob_head_valid_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_head_complete_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_head_has_dest_i,
  input  logic [RETIRE_WIDTH-1:0][AW-1:0]  rob_head_arch_reg_i,
  input  logic [RETIRE_WIDTH-1:0][PW-1:0]  rob_head_tag_i,
  input  logic [RETIRE_WIDTH-1:0]          rob_head_mispredict_i,
  input  logic [RETIRE_WIDTH-1:0][PW-1:0]  at_tag_i,
  output logic [RETIRE_WIDTH-1:0]          retire_en_o,
  output logic [RETIRE_WIDTH-1:0][AW-1:0]  retire_arch_reg_o,
  output logic [RETIRE_WIDTH-1:0][PW-1:0]  new_tag_o,
  output logic [CNTW-1:0]                  rob_retire_cnt_o,
  output logic [RETIRE_WIDTH-1:0]          free_en_o,
  output logic [RETIRE_WIDTH-1:0][PW-1:0]  free_tag_o,
  output logic                             flush_o,
  output logic                             recover_busy_o,
  output logic [31:0]                      retired_total_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Down-counter width; it holds values 0 .. RECOVER_CYCLES-1.
  localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CW-1:0] RCNT_INIT =
      (RECOVER_CYCLES > 0) ? CW'(RECOVER_CYCLES - 1) : '0;

  state_t                  state_q, state_d;
  logic [CW-1:0]           rcnt_q, rcnt_d;
  logic                    flush_q;
  logic                    busy_q;
  logic [31:0]             total_q;

  logic [RETIRE_WIDTH-1:0] retires;
  logic [RETIRE_WIDTH-1:0] writes;
  logic                    prefix_ok;
  logic                    mispredict_fire;
  logic [CNTW-1:0]         cnt;

  // Retire selection. The run flag falls as soon as a slot is not ready. It
  // also falls after a mispredicted slot, so that the branch itself retires
  // but younger slots do not. Because the flag is already low at an invalid
  // slot, that slot's other fields never matter.
  always_comb begin
    retires   = '0;
    prefix_ok = (state_q == RUN) && !reset;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      prefix_ok  = prefix_ok & rob_head_valid_i[i] & rob_head_complete_i[i];
      retires[i] = prefix_ok;
      prefix_ok  = prefix_ok & ~rob_head_mispredict_i[i];
    end
  end

  // x0 is hardwired, so it is never written and its tag is never freed.
  always_comb begin
    writes = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      writes[i] = retires[i] & rob_head_has_dest_i[i] &
                  (rob_head_arch_reg_i[i] != '0);
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      cnt = cnt + CNTW'(retires[i]);
    end
  end

  assign mispredict_fire = |(retires & rob_head_mispredict_i);

  genvar gi;
  generate
    for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_slot
      logic          en_c;
      logic [PW-1:0] ftag_c;

      // Only the youngest write to a register in the group reaches
      // arch_table. The tag it displaces is the one written by the next
      // older same-reg write in the group. If there is none, it is the
      // committed mapping read from arch_table.
      always_comb begin
        en_c   = writes[gi];
        ftag_c = at_tag_i[gi];
        for (int k = gi + 1; k < RETIRE_WIDTH; k++) begin
          if (writes[k] && (rob_head_arch_reg_i[k] == rob_head_arch_reg_i[gi])) begin
            en_c = 1'b0;
          end
        end
        for (int j = 0; j < gi; j++) begin
          if (writes[j] && (rob_head_arch_reg_i[j] == rob_head_arch_reg_i[gi])) begin
            ftag_c = rob_head_tag_i[j];
          end
        end
      end

      assign retire_en_o[gi]       = en_c;
      assign free_en_o[gi]         = writes[gi];
      assign free_tag_o[gi]        = writes[gi] ? ftag_c : '0;
      // Gate by valid so that empty head slots leave the outputs quiet.
      assign retire_arch_reg_o[gi] = (rob_head_valid_i[gi] && !reset) ?
                                     rob_head_arch_reg_i[gi] : '0;
      assign new_tag_o[gi]         = (rob_head_valid_i[gi] && !reset) ?
                                     rob_head_tag_i[gi] : '0;
    end
  endgenerate

  assign rob_retire_cnt_o = cnt;

  // Recovery FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      RUN: begin
        if (mispredict_fire) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (RECOVER_CYCLES == 0) begin
          state_d = RUN;
        end else begin
          state_d = RECOVER;
          rcnt_d  = RCNT_INIT;
        end
      end
      RECOVER: begin
        if (rcnt_q == '0) begin
          state_d = RUN;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      flush_q <= (state_d == FLUSH);
      busy_q  <= (state_d != RUN);
      if (state_q == RUN) begin
        total_q <= total_q + 32'(cnt);
      end
    end
  end

  assign flush_o         = flush_q;
  assign recover_busy_o  = busy_q;
  assign retired_total_o = total_q;

endmodule

// File: tb/tb_retire_ctrl.sv
// Scoreboard bench for retire_ctrl: directed per-cycle vectors push their
// hand-computed expected outputs; a monitor pops one entry per cycle on the
// falling edge and compares.
module tb_retire_ctrl;

  localparam int RW = 2;
  localparam int AW = 5;
  localparam int PW = 6;

  logic                 clk;
  logic                 reset;
  logic [RW-1:0]        valid, complete, has_dest, mispredict;
  logic [RW-1:0][AW-1:0] arch_reg;
  logic [RW-1:0][PW-1:0] tag, at_tag;
  logic [RW-1:0]        retire_en, free_en;
  logic [RW-1:0][AW-1:0] retire_arch_reg;
  logic [RW-1:0][PW-1:0] new_tag, free_tag;
  logic [1:0]           cnt;
  logic                 flush, busy;
  logic [31:0]          total;

  retire_ctrl #(
    .RETIRE_WIDTH(2), .ARCH_REGS(32), .PREG_NUM(64), .RECOVER_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rob_head_valid_i(valid),
    .rob_head_complete_i(complete),
    .rob_head_has_dest_i(has_dest),
    .rob_head_arch_reg_i(arch_reg),
    .rob_head_tag_i(tag),
    .rob_head_mispredict_i(mispredict),
    .at_tag_i(at_tag),
    .retire_en_o(retire_en),
    .retire_arch_reg_o(retire_arch_reg),
    .new_tag_o(new_tag),
    .rob_retire_cnt_o(cnt),
    .free_en_o(free_en),
    .free_tag_o(free_tag),
    .flush_o(flush),
    .recover_busy_o(busy),
    .retired_total_o(total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  en;
    logic [1:0]  cnt;
    logic [1:0]  fen;
    logic [5:0]  ft0;
    logic [5:0]  ft1;
    logic        flush;
    logic        busy;
    logic [31:0] total;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   stim_done = 0;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic step(input string nm, input logic rst,
                      input logic [1:0] v, input logic [1:0] c,
                      input logic [1:0] hd, input logic [1:0] mp,
                      input logic [4:0] r0, input logic [4:0] r1,
                      input logic [5:0] t0, input logic [5:0] t1,
                      input logic [5:0] a0, input logic [5:0] a1,
                      input logic [1:0] e_en, input logic [1:0] e_cnt,
                      input logic [1:0] e_fen, input logic [5:0] e_ft0,
                      input logic [5:0] e_ft1, input logic e_flush,
                      input logic e_busy, input logic [31:0] e_total);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    valid       = v;
    complete    = c;
    has_dest    = hd;
    mispredict  = mp;
    arch_reg[0] = r0;
    arch_reg[1] = r1;
    tag[0]      = t0;
    tag[1]      = t1;
    at_tag[0]   = a0;
    at_tag[1]   = a1;
    e.name  = nm;
    e.en    = e_en;
    e.cnt   = e_cnt;
    e.fen   = e_fen;
    e.ft0   = e_ft0;
    e.ft1   = e_ft1;
    e.flush = e_flush;
    e.busy  = e_busy;
    e.total = e_total;
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison per queued cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({retire_en, cnt, free_en, free_tag[0], free_tag[1], flush, busy, total} !==
            {e.en, e.cnt, e.fen, e.ft0, e.ft1, e.flush, e.busy, e.total}) begin
          fails++;
          $display("FAIL %s: got en=%b cnt=%0d fen=%b ft0=%h ft1=%h flush=%b busy=%b total=%0d ; want en=%b cnt=%0d fen=%b ft0=%h ft1=%h flush=%b busy=%b total=%0d",
                   e.name, retire_en, cnt, free_en, free_tag[0], free_tag[1], flush, busy, total,
                   e.en, e.cnt, e.fen, e.ft0, e.ft1, e.flush, e.busy, e.total);
        end else begin
          $display("[TB] %s ok: en=%b cnt=%0d fen=%b ft0=%h ft1=%h flush=%b busy=%b total=%0d",
                   e.name, retire_en, cnt, free_en, free_tag[0], free_tag[1], flush, busy, total);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    valid = '0; complete = '0; has_dest = '0; mispredict = '0;
    arch_reg = '0; tag = '0; at_tag = '0;
    repeat (2) @(posedge clk);

    //    name        rst v     c     hd    mp    r0 r1  t0     t1     a0     a1     en    cnt fen   ft0    ft1    fl bz total
    step("reset",     1, 2'b11, 2'b11, 2'b11, 2'b00, 1, 2, 6'h05, 6'h06, 6'h01, 6'h02, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 0, 0);
    step("one_slot",  0, 2'b01, 2'b01, 2'b01, 2'b00, 1, 2, 6'h33, 6'h00, 6'h01, 6'h00, 2'b01, 1, 2'b01, 6'h01, 6'h00, 0, 0, 0);
    step("hol_stall", 0, 2'b11, 2'b10, 2'b11, 2'b00, 3, 4, 6'h12, 6'h13, 6'h02, 6'h03, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 0, 1);
    step("same_reg",  0, 2'b11, 2'b11, 2'b11, 2'b00, 5, 5, 6'h10, 6'h11, 6'h07, 6'h07, 2'b10, 2, 2'b11, 6'h07, 6'h10, 0, 0, 1);
    step("x0_nodest", 0, 2'b11, 2'b11, 2'b01, 2'b00, 0, 6, 6'h14, 6'h15, 6'h08, 6'h09, 2'b00, 2, 2'b00, 6'h00, 6'h00, 0, 0, 3);
    step("diff_pair", 0, 2'b11, 2'b11, 2'b11, 2'b00, 7, 8, 6'h20, 6'h21, 6'h0A, 6'h0B, 2'b11, 2, 2'b11, 6'h0A, 6'h0B, 0, 0, 5);
    step("inv_slot0", 0, 2'b10, 2'b11, 2'b11, 2'b01, 7, 8, 6'h22, 6'h23, 6'h0A, 6'h0B, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 0, 7);
    step("mp_T",      0, 2'b11, 2'b11, 2'b11, 2'b01, 9, 10, 6'h30, 6'h31, 6'h0C, 6'h0D, 2'b01, 1, 2'b01, 6'h0C, 6'h00, 0, 0, 7);
    step("mp_T+1",    0, 2'b11, 2'b11, 2'b11, 2'b00, 9, 10, 6'h30, 6'h31, 6'h0C, 6'h0D, 2'b00, 0, 2'b00, 6'h00, 6'h00, 1, 1, 8);
    step("mp_T+2",    0, 2'b11, 2'b11, 2'b11, 2'b11, 9, 10, 6'h30, 6'h31, 6'h0C, 6'h0D, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 1, 8);
    step("mp_T+3",    0, 2'b11, 2'b11, 2'b11, 2'b00, 9, 10, 6'h30, 6'h31, 6'h0C, 6'h0D, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 1, 8);
    step("mp_T+4",    0, 2'b11, 2'b11, 2'b11, 2'b00, 9, 10, 6'h30, 6'h31, 6'h0C, 6'h0D, 2'b11, 2, 2'b11, 6'h0C, 6'h0D, 0, 0, 8);
    step("mp_slot1",  0, 2'b11, 2'b11, 2'b11, 2'b10, 11, 12, 6'h40, 6'h41, 6'h0E, 6'h0F, 2'b11, 2, 2'b11, 6'h0E, 6'h0F, 0, 0, 10);
    step("mp1_T+1",   0, 2'b11, 2'b11, 2'b11, 2'b00, 11, 12, 6'h40, 6'h41, 6'h0E, 6'h0F, 2'b00, 0, 2'b00, 6'h00, 6'h00, 1, 1, 12);
    step("rst_in_rec",1, 2'b11, 2'b11, 2'b11, 2'b00, 11, 12, 6'h40, 6'h41, 6'h0E, 6'h0F, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 1, 12);
    step("after_rst", 0, 2'b01, 2'b01, 2'b01, 2'b00, 13, 0, 6'h2A, 6'h00, 6'h10, 6'h00, 2'b01, 1, 2'b01, 6'h10, 6'h00, 0, 0, 0);
    step("idle",      0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 0, 1);
    step("fwd_x0_mix",0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 6'h3E, 6'h3F, 6'h01, 6'h02, 2'b00, 2, 2'b00, 6'h00, 6'h00, 0, 0, 1);
    step("post_x0",   0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00, 2'b00, 0, 2'b00, 6'h00, 6'h00, 0, 0, 3);
    stim_done = 1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    wait (stim_done);
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
